tl_countdown_display: RTL and testbench
=======================================

# tl_countdown_display

Downstream display stage for the traffic-light controller. Takes the controller's remaining-time values (`time_ns`, `time_ew`) and `lights` vector, converts both times to two-digit BCD with an iterative double-dabble engine, and drives a 4-digit, time-multiplexed, common-anode 7-segment display. The decimal points flag the green direction.

## Interface
- `CLK_DIV`, default 50000: `clk` cycles per digit-scan step; legal range ≥2.
- `TIME_W`, default 7: width of the time inputs.
- `BLINK_DIV`, default 12: blink half-period exponent, as a bit index into a free-running counter. Used only with `TL_DISP_BLINK_EN`.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `time_ns  in  TIME_W`: NS seconds remaining, unsigned.
- `time_ew  in  TIME_W`: EW seconds remaining, unsigned.
- `lights  in  6`: {NS red, NS yellow, NS green, EW red, EW yellow, EW green}.
- `seg_n  out  7`: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n  out  1`: decimal point, active-low.
- `an_n  out  4`: digit enables, active-low, one-hot. an[3]/an[2] = NS tens/ones; an[1]/an[0] = EW tens/ones.

## Operation
- **Conversion FSM states:** IDLE, CONV_NS, CONV_EW, LATCH.
  - IDLE (1 cycle): samples `time_ns`, `time_ew` and `lights`. Goes to CONV_NS.
  - CONV_NS (7 cycles): double-dabble on the sampled NS value. Goes to CONV_EW.
  - CONV_EW (7 cycles): double-dabble on the sampled EW value. Goes to LATCH.
  - LATCH (1 cycle): loads the display registers. Goes to IDLE.
- **Clamp:** a sampled value ≥100 is replaced by 99 before conversion.
- **Arithmetic:** 8-bit BCD shift register plus 7-bit binary. Add 3 to any nibble ≥5 before each shift.
- **Blanking:**
  - A value of 0 blanks both of its digits (`seg_n=7'h7F`).
  - A value of 1–9 blanks the tens digit (leading-zero suppression).
- **Decimal point:** the ones digit lights its dp when its direction's green bit is set: `lights[3]` for NS, `lights[0]` for EW. Tens digits never light a dp.
- **Digit scan:**
  - A scan counter counts 0..CLK_DIV-1. On wrap, the digit index advances 3→2→1→0→3.
  - `an_n` selects the indexed digit.
  - `seg_n` and `dp_n` show that digit's glyph.
- **Glyphs:**
  - Digits 0–9 use standard encodings, e.g. 0=`7'b1000000`, 1=`7'b1111001`, 8=`7'b0000000`, 9=`7'b0010000`.
  - Undefined BCD values show blank.

## Timing
- **Reset values:**
  - Outputs: `seg_n=7'h7F`, `an_n=4'b0111`, `dp_n=1`.
  - Internal: display registers hold 0 (blank), FSM in IDLE, digit index 3, scan counter 0, blink counter 0.
- **Conversion latency and refresh:**
  - Update period is 16 cycles.
  - Display registers reflect inputs sampled in IDLE at cycle t from cycle t+16.
  - Input changes between samples are ignored until the next IDLE.
- **Output registering:**
  - All outputs are registered.
  - `an_n`, `seg_n` and `dp_n` change together, 1 cycle after the digit index changes.
  - A display-register update shows on the currently enabled digit 1 cycle after LATCH.
- **Reset mid-conversion:** aborts, FSM returns to IDLE, display registers clear.
- **Clamp boundaries:**
  - 99 displays 99; 100 displays 99; 127 displays 99.
  - 10 displays "10"; 9 displays " 9".
- **Simultaneous LATCH and scan step:** the new digit shows the newly latched value.

## Configuration
- **`TL_DISP_BLINK_EN` defined:**
  - A free-running counter runs; bit `BLINK_DIV` gives the blink phase.
  - While a direction's latched value is 1–3, its two digits (and their dp) are blanked when the phase bit is 1.
  - Values 0 and ≥4 never blink.
- **Not defined:** no blink counter and no blinking; `BLINK_DIV` is unused.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `seg_n=7'h7F`, `an_n=4'b0111`, `dp_n=1`. Hold 100 cycles with no input changes → outputs unchanged.
- **Basic display:** `CLK_DIV=4`, `time_ns=42`, `time_ew=7`, `lights=6'b100001` → from cycle 17 the scan yields:
  - an[3]: "4", dp off.
  - an[2]: "2", dp off.
  - an[1]: blank.
  - an[0]: "7", dp on.
  - Digit changes every 4 cycles.
- **Clamp and blank:** `time_ns=120`, `time_ew=0`, `lights=6'b001100` → NS shows "99" with the dp on the NS ones digit; both EW digits blank.
- **Mid-conversion change:**
  - `time_ns` changes 5→63 during CONV_NS → the current update keeps 5; 63 appears one period later.
  - `rst` at cycle 8 of CONV_EW → display blank; a new sample follows.
- **Blink (`TL_DISP_BLINK_EN`, `BLINK_DIV=3`):**
  - `time_ew=2` → EW ones digit alternates "2"/blank every 8 cycles.
  - `time_ns=4` → never blinks.
- **Full sweep:** `time_ns` 0..127 → every decoded digit pair matches the clamped decimal value.

Source files
------------

// File: rtl/tl_countdown_display_if.sv
// Countdown display bus: controller times and lights in, 7-segment drive out.
// master drives the times/lights, slave is the display stage.
interface tl_countdown_display_if #(
  parameter int TIME_W = 7
);
  logic [TIME_W-1:0] time_ns;
  logic [TIME_W-1:0] time_ew;
  logic [5:0]        lights;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [3:0]        an_n;

  modport master (output time_ns, time_ew, lights, input seg_n, dp_n, an_n);
  modport slave  (input time_ns, time_ew, lights, output seg_n, dp_n, an_n);
endinterface

// File: rtl/tl_countdown_display.sv
// Traffic-light countdown display: double-dabble BCD conversion and 4-digit 7-segment scan.
// Optional blinking of the last seconds (1..3) when TL_DISP_BLINK_EN is defined.
//
// state   | meaning
// IDLE    | sample times (clamped to 99) and green bits, load NS into converter
// CONV_NS | 7 double-dabble steps on NS, then park result and load EW
// CONV_EW | 7 double-dabble steps on EW
// LATCH   | load display registers
module tl_countdown_display #(
  parameter int CLK_DIV   = 50000,
  parameter int TIME_W    = 7,
  parameter int BLINK_DIV = 12
) (
  input logic                   clk,
  input logic                   rst,
  tl_countdown_display_if.slave disp
);

  localparam int SCAN_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, CONV_NS, CONV_EW, LATCH} state_t;

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic              bit_last;
  logic              smp_en, conv_en, ns_done, latch_en;
  logic [7:0]        dd_bcd, dd_adj, dd_bcd_nxt;
  logic [6:0]        dd_bin, dd_bin_nxt;
  logic [6:0]        ew_smp;
  logic              ns_grn_smp, ew_grn_smp;
  logic [7:0]        ns_res;
  logic [7:0]        disp_ns, disp_ew;
  logic              disp_ns_grn, disp_ew_grn;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;
  logic              blink_ph;
  logic [7:0]        cur_val;
  logic              cur_grn, cur_blink, cur_blank, cur_dp;
  logic [3:0]        cur_nib;
  logic              unused_bits;

  function automatic logic [6:0] clamp99(input logic [TIME_W-1:0] v);
    if (32'(v) >= 32'd100) return 7'd99;
    return 7'(v);
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign bit_last    = (bit_cnt == 3'd6);
  assign unused_bits = ^{disp.lights[5:4], disp.lights[2:1], dd_adj[7]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = CONV_NS;
      CONV_NS: if (bit_last) state_nxt = CONV_EW;
      CONV_EW: if (bit_last) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    smp_en   = 1'b0;
    conv_en  = 1'b0;
    ns_done  = 1'b0;
    latch_en = 1'b0;
    case (state)
      IDLE:    smp_en = 1'b1;
      CONV_NS: begin conv_en = 1'b1; ns_done = bit_last; end
      CONV_EW: conv_en = 1'b1;
      LATCH:   latch_en = 1'b1;
      default: ;
    endcase
  end

  // add-3 correction on each nibble, then shift the {bcd, bin} pair left
  always_comb begin
    dd_adj = dd_bcd;
    if (dd_bcd[3:0] >= 4'd5) dd_adj[3:0] = dd_bcd[3:0] + 4'd3;
    if (dd_bcd[7:4] >= 4'd5) dd_adj[7:4] = dd_bcd[7:4] + 4'd3;
    dd_bcd_nxt = {dd_adj[6:0], dd_bin[6]};
    dd_bin_nxt = {dd_bin[5:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      dd_bcd     <= '0;
      dd_bin     <= '0;
      ew_smp     <= '0;
      ns_grn_smp <= 1'b0;
      ew_grn_smp <= 1'b0;
      ns_res     <= '0;
    end else begin
      if (smp_en) begin
        dd_bcd     <= '0;
        dd_bin     <= clamp99(disp.time_ns);
        ew_smp     <= clamp99(disp.time_ew);
        ns_grn_smp <= disp.lights[3];
        ew_grn_smp <= disp.lights[0];
      end else if (ns_done) begin
        ns_res <= dd_bcd_nxt;
        dd_bcd <= '0;
        dd_bin <= ew_smp;
      end else if (conv_en) begin
        dd_bcd <= dd_bcd_nxt;
        dd_bin <= dd_bin_nxt;
      end
      bit_cnt <= (conv_en && !bit_last) ? bit_cnt + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_ns     <= '0;
      disp_ew     <= '0;
      disp_ns_grn <= 1'b0;
      disp_ew_grn <= 1'b0;
    end else if (latch_en) begin
      disp_ns     <= ns_res;
      disp_ew     <= dd_bcd;
      disp_ns_grn <= ns_grn_smp;
      disp_ew_grn <= ew_grn_smp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd3;
    end else if (scan_cnt == SCAN_W'(CLK_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx - 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef TL_DISP_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + (BLINK_DIV+1)'(1);
  end

  assign blink_ph = blink_cnt[BLINK_DIV];
`else
  // no blinking: phase is permanently low
  assign blink_ph = (BLINK_DIV < 0);
`endif

  // dig_idx[1] selects NS, dig_idx[0] selects the tens digit
  always_comb begin
    cur_val = disp_ew;
    cur_grn = disp_ew_grn;
    if (dig_idx[1]) begin
      cur_val = disp_ns;
      cur_grn = disp_ns_grn;
    end
    cur_blink = blink_ph && (cur_val >= 8'h01) && (cur_val <= 8'h03);
    if (dig_idx[0]) begin
      cur_nib   = cur_val[7:4];
      cur_blank = (cur_val[7:4] == 4'd0);
      cur_dp    = 1'b0;
    end else begin
      cur_nib   = cur_val[3:0];
      cur_blank = (cur_val == 8'h00);
      cur_dp    = cur_grn;
    end
    if (cur_blink) begin
      cur_blank = 1'b1;
      cur_dp    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp.seg_n <= 7'h7F;
      disp.an_n  <= 4'b0111;
      disp.dp_n  <= 1'b1;
    end else begin
      disp.seg_n <= cur_blank ? 7'h7F : glyph(cur_nib);
      disp.an_n  <= ~(4'b0001 << dig_idx);
      disp.dp_n  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_tl_countdown_display.sv
// Self-checking bench for tl_countdown_display: timed sequences, vector table, value sweep.
module tb_tl_countdown_display;
  localparam int CLK_DIV   = 4;
  localparam int TIME_W    = 7;
  localparam int BLINK_DIV = 3;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, BL = 7'h7F;
  localparam logic [6:0] GL [10] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};

  typedef struct {
    logic [6:0]      ns;
    logic [6:0]      ew;
    logic [5:0]      lt;
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  tl_countdown_display_if #(.TIME_W(TIME_W)) bus ();

  tl_countdown_display #(
    .CLK_DIV  (CLK_DIV),
    .TIME_W   (TIME_W),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [6:0] ns, input logic [6:0] ew, input logic [5:0] lt);
    bus.time_ns = ns;
    bus.time_ew = ew;
    bus.lights  = lt;
  endtask

  task automatic capture(output logic [3:0][6:0] seg, output logic [3:0] dp, output int bad_an);
    seg    = 'x;
    dp     = 'x;
    bad_an = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge clk);
      case (bus.an_n)
        4'b0111: begin seg[3] = bus.seg_n; dp[3] = bus.dp_n; end
        4'b1011: begin seg[2] = bus.seg_n; dp[2] = bus.dp_n; end
        4'b1101: begin seg[1] = bus.seg_n; dp[1] = bus.dp_n; end
        4'b1110: begin seg[0] = bus.seg_n; dp[0] = bus.dp_n; end
        default: bad_an++;
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][6:0] cap_seg;
    logic [3:0]      cap_dp;
    int              bad_an;
    logic [3:0][6:0] b_seg;
    logic [3:0]      b_dp;
    int              d, c;
    logic [6:0]      exp_t, exp_o;

    vecs[0] = '{ns:7'd42,  ew:7'd7,  lt:6'b100001, seg:{G4, G2, BL, G7}, dp:4'b1110};
    vecs[1] = '{ns:7'd120, ew:7'd0,  lt:6'b001100, seg:{G9, G9, BL, BL}, dp:4'b1011};
    vecs[2] = '{ns:7'd99,  ew:7'd10, lt:6'b100001, seg:{G9, G9, G1, G0}, dp:4'b1110};
    vecs[3] = '{ns:7'd100, ew:7'd9,  lt:6'b001100, seg:{G9, G9, BL, G9}, dp:4'b1011};
    vecs[4] = '{ns:7'd127, ew:7'd5,  lt:6'b010100, seg:{G9, G9, BL, G5}, dp:4'b1111};
    vecs[5] = '{ns:7'd0,   ew:7'd55, lt:6'b100010, seg:{BL, BL, G5, G5}, dp:4'b1111};
    vecs[6] = '{ns:7'd80,  ew:7'd36, lt:6'b001100, seg:{G8, G0, G3, G6}, dp:4'b1011};
    vecs[7] = '{ns:7'd17,  ew:7'd64, lt:6'b100001, seg:{G1, G7, G6, G4}, dp:4'b1110};

    // reset values, then a quiet hold with zero inputs
    set_in(7'd0, 7'd0, 6'b0);
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("reset_seg", 32'(bus.seg_n), 32'h7F);
    chk("reset_an",  32'(bus.an_n),  32'b0111);
    chk("reset_dp",  32'(bus.dp_n),  32'd1);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      goto(k);
      chk($sformatf("hold_seg_c%0d", k), 32'(bus.seg_n), 32'h7F);
      chk($sformatf("hold_dp_c%0d", k),  32'(bus.dp_n),  32'd1);
    end

    // basic display: first latched value appears at cycle 17
    set_in(7'd42, 7'd7, 6'b100001);
    do_reset(2);
    b_seg = {G4, G2, BL, G7};
    b_dp  = 4'b1110;
    goto(16);
    chk("basic_c16", {25'd0, bus.an_n, bus.dp_n, bus.seg_n[1:0]}, {25'd0, 4'b1110, 1'b1, 2'b11});
    chk("basic_c16_seg", 32'(bus.seg_n), 32'(BL));
    for (int k = 17; k <= 32; k++) begin
      goto(k);
      d = 3 - (k - 17) / 4;
      chk($sformatf("basic_c%0d", k), {20'd0, bus.an_n, bus.dp_n, bus.seg_n},
          {20'd0, ~(4'b0001 << d), b_dp[d], b_seg[d]});
    end

    // input change during CONV_NS is ignored until the next sample
    set_in(7'd5, 7'd0, 6'b0);
    do_reset(2);
    goto(3);
    bus.time_ns = 7'd63;
    goto(17);
    chk("mid_tens_c17", {bus.an_n, bus.seg_n}, {4'b0111, BL});
    goto(22);
    chk("mid_ones_c22", {bus.an_n, bus.seg_n}, {4'b1011, G5});
    goto(33);
    chk("mid_tens_c33", {bus.an_n, bus.seg_n}, {4'b0111, G6});
    goto(38);
    chk("mid_ones_c38", {bus.an_n, bus.seg_n}, {4'b1011, G3});

    // reset during CONV_EW clears the display, then a new sample appears
    goto(41);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    @(negedge clk);
    chk("rstmid_out", {bus.an_n, bus.dp_n, bus.seg_n}, {4'b0111, 1'b1, BL});
    goto(5);
    chk("rstmid_clear_c5", {bus.an_n, bus.seg_n}, {4'b1011, BL});
    goto(16);
    chk("rstmid_clear_c16", {bus.an_n, bus.seg_n}, {4'b1110, BL});
    goto(17);
    chk("rstmid_new_c17", {bus.an_n, bus.seg_n}, {4'b0111, G6});

    // vector table
    for (int v = 0; v < 8; v++) begin
      set_in(vecs[v].ns, vecs[v].ew, vecs[v].lt);
      repeat (34) step();
      capture(cap_seg, cap_dp, bad_an);
      chk($sformatf("vec%0d_an", v), 32'(bad_an), 32'd0);
      for (int g = 0; g < 4; g++)
        chk($sformatf("vec%0d_dig%0d", v, g), {24'd0, cap_dp[g], cap_seg[g]},
            {24'd0, vecs[v].dp[g], vecs[v].seg[g]});
    end

    // full NS sweep against the clamped decimal value
    for (int v = 0; v < 128; v++) begin
`ifdef TL_DISP_BLINK_EN
      if (v >= 1 && v <= 3) continue;
`endif
      set_in(7'(v), 7'd50, 6'b0);
      repeat (34) step();
      capture(cap_seg, cap_dp, bad_an);
      c     = (v >= 100) ? 99 : v;
      exp_t = (c < 10) ? BL : GL[c / 10];
      exp_o = (c == 0) ? BL : GL[c % 10];
      chk($sformatf("sweep%0d_tens", v), 32'(cap_seg[3]), 32'(exp_t));
      chk($sformatf("sweep%0d_ones", v), 32'(cap_seg[2]), 32'(exp_o));
    end

`ifdef TL_DISP_BLINK_EN
    // blink: EW=2 follows the phase bit, NS=4 never blinks
    set_in(7'd4, 7'd2, 6'b0);
    do_reset(2);
    for (int k = 34; k < 98; k++) begin
      goto(k);
      d = 3 - (((k - 1) / 4) % 4);
      case (d)
        3:       exp_o = BL;
        2:       exp_o = G4;
        1:       exp_o = BL;
        default: exp_o = (((k - 1) >> BLINK_DIV) & 1) != 0 ? BL : G2;
      endcase
      chk($sformatf("blink_c%0d", k), {bus.an_n, bus.seg_n}, {~(4'b0001 << d), exp_o});
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
